// File: rtl/usb_rx_unstuffer.sv
// USB receive bit unstuffer: drops stuffed zeros after STUFF_LEN ones,
// assembles LSB-first bytes and flags stuffing and alignment errors.
module usb_rx_unstuffer #(
   parameter int STUFF_LEN = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_bit,
   input  logic       rx_bit_valid,
   input  logic       rx_active,
   output logic [7:0] rx_data,
   output logic       rx_data_valid,
   output logic       stuff_error,
   output logic       align_error
);

   localparam int ONES_W = $clog2(STUFF_LEN + 1);
   localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);

   typedef enum logic [1:0] {
      IDLE,
      RECEIVE,
      ERROR
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ONES_W-1:0] ones_cnt;
   logic [ONES_W-1:0] ones_next;
   logic [ONES_W-1:0] base_ones;
   logic [2:0]        bit_cnt;
   logic [2:0]        bits_next;
   logic [2:0]        base_bits;
   logic [7:0]        shift_reg;
   logic [7:0]        shift_next;
   logic              do_bit;
   logic              byte_done;
   logic              stuff_violation;
   logic              align_next;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Bit processing; a bit accepted in IDLE is the first bit of a new packet,
   // so the counters are taken as zero there regardless of their stored value.
   always_comb begin
      base_ones       = (state == IDLE) ? '0 : ones_cnt;
      base_bits       = (state == IDLE) ? '0 : bit_cnt;
      do_bit          = rx_bit_valid && rx_active && (state != ERROR);
      ones_next       = base_ones;
      bits_next       = base_bits;
      shift_next      = shift_reg;
      byte_done       = 1'b0;
      stuff_violation = 1'b0;
      align_next      = 1'b0;

      if (!rx_active) begin
         ones_next  = '0;
         bits_next  = '0;
         align_next = (state == RECEIVE) && (bit_cnt != 3'd0);
      end else if (do_bit) begin
         if (base_ones < STUFF_MAX) begin
            shift_next = {rx_bit, shift_reg[7:1]};
            bits_next  = base_bits + 3'd1;
            byte_done  = (base_bits == 3'd7);
            ones_next  = rx_bit ? (base_ones + ONES_W'(1)) : '0;
         end else if (!rx_bit) begin
            ones_next = '0;
         end else begin
            stuff_violation = 1'b1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (rx_active) begin
               state_next = stuff_violation ? ERROR : RECEIVE;
            end
         end
         RECEIVE: begin
            if (!rx_active) begin
               state_next = IDLE;
            end else if (stuff_violation) begin
               state_next = ERROR;
            end
         end
         ERROR: begin
            if (!rx_active) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Moore output: the stuffing error lasts exactly as long as the ERROR state
   always_comb begin
      stuff_error = (state == ERROR);
   end

   // Datapath registers and registered output pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ones_cnt      <= '0;
         bit_cnt       <= '0;
         shift_reg     <= '0;
         rx_data       <= 8'h00;
         rx_data_valid <= 1'b0;
         align_error   <= 1'b0;
      end else begin
         ones_cnt      <= ones_next;
         bit_cnt       <= bits_next;
         shift_reg     <= shift_next;
         rx_data_valid <= byte_done;
         align_error   <= align_next;
         if (byte_done) begin
            rx_data <= shift_next;
         end
      end
   end

endmodule

// File: tb/tb_usb_rx_unstuffer.sv
// Directed self-checking bench for usb_rx_unstuffer with hand-computed
// expected bytes and pulse timing.
module tb_usb_rx_unstuffer;

   logic       clk;
   logic       reset;
   logic       rx_bit;
   logic       rx_bit_valid;
   logic       rx_active;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       stuff_error;
   logic       align_error;

   int checks;
   int passed;

   usb_rx_unstuffer #(.STUFF_LEN(6)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_bit       (rx_bit),
      .rx_bit_valid (rx_bit_valid),
      .rx_active    (rx_active),
      .rx_data      (rx_data),
      .rx_data_valid(rx_data_valid),
      .stuff_error  (stuff_error),
      .align_error  (align_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then return 1 time unit after the capturing edge
   task automatic applyStimulus(input logic active, input logic valid, input logic b);
      rx_active    = active;
      rx_bit_valid = valid;
      rx_bit       = b;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   initial begin
      logic [7:0] val;
      checks       = 0;
      passed       = 0;
      reset        = 1'b1;
      rx_bit       = 1'b0;
      rx_bit_valid = 1'b0;
      rx_active    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_rx_data", rx_data, 8'h00);
      checkOutput("reset_valid", 8'(rx_data_valid), 8'h00);
      checkOutput("reset_stuff", 8'(stuff_error), 8'h00);
      checkOutput("reset_align", 8'(align_error), 8'h00);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Byte A5 sent LSB-first
      val = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b1, val[i]);
         if (i < 7) checkOutput("a5_no_early_valid", 8'(rx_data_valid), 8'h00);
      end
      checkOutput("a5_valid", 8'(rx_data_valid), 8'h01);
      checkOutput("a5_data", rx_data, 8'hA5);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("a5_valid_one_cycle", 8'(rx_data_valid), 8'h00);
      checkOutput("a5_data_hold", rx_data, 8'hA5);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("a5_end_no_align", 8'(align_error), 8'h00);

      // Six ones, a stuffed zero, then two more ones -> FF
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("ff_no_valid_after_8", 8'(rx_data_valid), 8'h00);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("ff_valid", 8'(rx_data_valid), 8'h01);
      checkOutput("ff_data", rx_data, 8'hFF);
      checkOutput("ff_no_stuff_err", 8'(stuff_error), 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("ff_end_no_align", 8'(align_error), 8'h00);

      // Seven consecutive ones -> stuffing violation
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("err_not_yet", 8'(stuff_error), 8'h00);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("err_set", 8'(stuff_error), 8'h01);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
         checkOutput("err_hold", 8'(stuff_error), 8'h01);
         checkOutput("err_no_valid", 8'(rx_data_valid), 8'h00);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("err_cleared", 8'(stuff_error), 8'h00);
      checkOutput("err_no_align", 8'(align_error), 8'h00);
      checkOutput("err_data_kept", rx_data, 8'hFF);

      // Five data bits then packet end -> alignment error
      val = 8'h19;
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, val[i]);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("align_pulse", 8'(align_error), 8'h01);
      checkOutput("align_no_valid", 8'(rx_data_valid), 8'h00);
      checkOutput("align_data_kept", rx_data, 8'hFF);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("align_one_cycle", 8'(align_error), 8'h00);
      val = 8'h5A;
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, val[i]);
      checkOutput("after_align_valid", 8'(rx_data_valid), 8'h01);
      checkOutput("after_align_data", rx_data, 8'h5A);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Reset after four ones of a byte, then a fresh 3C packet
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1);
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("mid_reset_data", rx_data, 8'h00);
      checkOutput("mid_reset_valid", 8'(rx_data_valid), 8'h00);
      reset = 1'b0;
      val = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b1, val[i]);
         if (i < 7) checkOutput("3c_no_early_valid", 8'(rx_data_valid), 8'h00);
      end
      checkOutput("3c_valid", 8'(rx_data_valid), 8'h01);
      checkOutput("3c_data", rx_data, 8'h3C);
      checkOutput("3c_no_stuff_err", 8'(stuff_error), 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Byte C3 with invalid cycles between every bit
      val = 8'hC3;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b1, val[i]);
         if (i < 7) begin
            applyStimulus(1'b1, 1'b0, ~val[i]);
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput("gap_no_valid", 8'(rx_data_valid), 8'h00);
         end
      end
      checkOutput("gap_valid", 8'(rx_data_valid), 8'h01);
      checkOutput("gap_data", rx_data, 8'hC3);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("gap_valid_one_cycle", 8'(rx_data_valid), 8'h00);

      // Seven bits, then an 8th bit arriving as rx_active falls is ignored
      val = 8'h66;
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, val[i]);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("late_bit_no_valid", 8'(rx_data_valid), 8'h00);
      checkOutput("late_bit_align", 8'(align_error), 8'h01);
      checkOutput("late_bit_data_kept", rx_data, 8'hC3);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("late_bit_align_clear", 8'(align_error), 8'h00);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/usb_rx_unstuffer.md
USB_RX_UNSTUFFER -- requirements
Module: usb_rx_unstuffer

Interface
REQ-001 Parameter: STUFF_LEN, default 6, number of consecutive 1 data bits after which the next bit is a stuffed bit.
REQ-002 clk  input  1  single clock; every register is clocked on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_bit  input  1  decoded NRZI bit from the upstream decoder.
REQ-005 rx_bit_valid  input  1  rx_bit is valid this cycle.
REQ-006 rx_active  input  1  high for the duration of a packet, low between packets.
REQ-007 rx_data  output  8  assembled byte, first received bit in rx_data[0].
REQ-008 rx_data_valid  output  1  one-cycle pulse; rx_data holds a new byte.
REQ-009 stuff_error  output  1  level; a bit-stuffing violation occurred in the current packet.
REQ-010 align_error  output  1  one-cycle pulse; the packet ended with a partial byte.

Function
REQ-011 The block SHALL accept a bit only in a cycle where rx_bit_valid=1 and rx_active=1, and SHALL ignore all other cycles.
REQ-012 The block SHALL implement the states IDLE, RECEIVE and ERROR.
REQ-013 IDLE SHALL be the state after reset; the block SHALL move IDLE->RECEIVE in any cycle with rx_active=1, and an accepted bit in that same cycle SHALL be processed as the first bit of the packet.
REQ-014 On entry to RECEIVE from IDLE, ones_cnt and bit_cnt SHALL start at 0.
REQ-015 An accepted bit with ones_cnt<STUFF_LEN SHALL be a data bit that is shifted in LSB-first, increments bit_cnt, and sets ones_cnt to ones_cnt+1 if rx_bit=1, otherwise to 0.
REQ-016 An accepted bit with ones_cnt=STUFF_LEN and rx_bit=0 SHALL be discarded as a stuffed bit, set ones_cnt to 0, and leave bit_cnt unchanged.
REQ-017 An accepted bit with ones_cnt=STUFF_LEN and rx_bit=1 SHALL move the block to ERROR, with stuff_error=1 from the next cycle.
REQ-018 ones_cnt SHALL carry across byte boundaries; only packet start and reset clear it.
REQ-019 When the 8th data bit of a byte is accepted, rx_data SHALL update and rx_data_valid SHALL pulse for exactly one cycle in the following cycle (latency: 1 clock), and bit_cnt SHALL wrap to 0.
REQ-020 rx_data SHALL hold its value between pulses and across packet boundaries.
REQ-021 In RECEIVE, rx_active=0 with bit_cnt!=0 SHALL pulse align_error for one cycle in the next cycle; the block SHALL return to IDLE and discard the partial byte.
REQ-022 In RECEIVE, rx_active=0 with bit_cnt=0 SHALL return the block to IDLE with no pulse.
REQ-023 If rx_active falls in the same cycle as rx_bit_valid=1, the bit SHALL be ignored per REQ-011.
REQ-024 In ERROR, the block SHALL ignore all bits, produce no rx_data_valid and no align_error, and hold stuff_error=1.
REQ-025 In ERROR, rx_active=0 SHALL return the block to IDLE, and stuff_error SHALL clear in the same transition.
REQ-026 rx_data_valid and align_error SHALL never be asserted in the same cycle.

Reset
REQ-027 While reset=1, the block SHALL be in IDLE with ones_cnt=0, bit_cnt=0, shift register=0, rx_data=8'h00, rx_data_valid=0, stuff_error=0 and align_error=0.
REQ-028 Reset asserted mid-byte or mid-packet SHALL discard all partial state; after release, the block SHALL wait in IDLE and, while rx_active=1, process the next accepted bit as a new packet start.

Verification
REQ-029 The bench SHALL cover: rx_active=1, bits 1,0,1,0,0,1,0,1 -> rx_data=8'hA5, rx_data_valid pulse 1 cycle after the last bit.
REQ-030 The bench SHALL cover: bits 1,1,1,1,1,1,0(stuffed),1,1 -> rx_data=8'hFF after 9 accepted bits, stuff_error=0.
REQ-031 The bench SHALL cover: seven consecutive 1 bits -> stuff_error=1 from the cycle after the 7th bit, no rx_data_valid, and stuff_error clears after rx_active falls.
REQ-032 The bench SHALL cover: 5 data bits then rx_active=0 -> a single align_error pulse, rx_data unchanged, and the block back in IDLE.
REQ-033 The bench SHALL cover: reset pulsed after 4 bits of a byte, then a fresh packet with bits 8'h3C LSB-first -> rx_data=8'h3C, with no leftover bits.
REQ-034 The bench SHALL cover: a byte whose 8th bit arrives with rx_bit_valid gaps between bits -> the same byte and the same 1-cycle latency after the 8th accepted bit.
